// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes and selects for each state. It also latches
// the opcode at decode and counts retired instructions.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic        mem_ready,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCUpdate,
    output logic        Branch,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUOp,
    output logic        illegal_op,
    output logic [3:0]  state_o,
    output logic [31:0] instret
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [3:0]  state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    // State, latched opcode and retire counter; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            instret_q <= instret_d;
        end
    end

    // Next-state selection; unused codes 10-15 fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Opcode capture at decode and retirement counting (wraps naturally at 2^32)
    always_comb begin
        op_d      = (state_q == S_DECODE) ? op : op_q;
        retire    = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                    ((state_q == S_MEMWRITE) && mem_ready);
        instret_d = instret_q + {31'd0, retire};
    end

    // Per-state datapath controls; only IRWrite/PCUpdate and illegal_op look at inputs
    always_comb begin
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        Branch     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                illegal_op = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ});
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op_q == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench for multicycle_controller: each instruction is expanded
// into its expected per-cycle trace, which a monitor compares every cycle.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef struct packed {
        logic       rw, mw, irw, pcu, br, adr;
        logic [1:0] a, b, rs, imm, aop;
        logic       ill;
    } outs_t;

    typedef struct packed {
        logic [3:0]  st;
        outs_t       o;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic        mem_ready;
    logic        RegWrite, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc, illegal_op;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp;
    logic [3:0]  state_o;
    logic [31:0] instret;

    exp_t        sb[$];
    logic [31:0] cnt;
    int          total = 0;
    int          bad   = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCUpdate(PCUpdate), .Branch(Branch), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUOp(ALUOp), .illegal_op(illegal_op),
        .state_o(state_o), .instret(instret)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t  e;
        outs_t act;
        if (rst_n && sb.size() > 0) begin
            e   = sb.pop_front();
            act = {RegWrite, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp, illegal_op};
            total++;
            if (state_o !== e.st || act !== e.o || instret !== e.cnt) begin
                bad++;
                $display("FAIL cycle t=%0t state got=%0d want=%0d ctrl got=%h want=%h instret got=%h want=%h",
                         $time, state_o, e.st, act, e.o, instret, e.cnt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // One cycle of stimulus plus its expected outcome; optional counter preload
    task automatic step(input logic rdy, input logic [6:0] o, input exp_t e, input bit pre);
        @(posedge clk);
        #1;
        if (pre) begin
            force dut.instret_q = 32'hFFFF_FFFF;
            #1;
            release dut.instret_q;
        end
        mem_ready = rdy;
        op        = o;
        sb.push_back(e);
    endtask

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.cnt = cnt;
        return e;
    endfunction

    // Expand one instruction into its cycle trace: fw/mw are memory wait cycles.
    // abort pulls reset during the first MEMWRITE wait cycle of a store.
    task automatic run_instr(input logic [6:0] o, input int fw, input int mw,
                             input bit pre, input bit abort);
        exp_t e;
        bit   legal;
        legal = o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ};
        if (pre) cnt = 32'hFFFF_FFFF;
        for (int i = 0; i <= fw; i++) begin
            e = blank(4'd0);
            e.o.b = 2'b10; e.o.rs = 2'b10;
            e.o.irw = (i == fw); e.o.pcu = (i == fw);
            step(i == fw, 7'($urandom), e, pre && i == 0);
        end
        e = blank(4'd1);
        e.o.a = 2'b01; e.o.b = 2'b01; e.o.imm = 2'b10; e.o.ill = !legal;
        step(1'($urandom), o, e, 1'b0);
        if (!legal) return;
        if (o == OP_LW || o == OP_SW) begin
            e = blank(4'd2);
            e.o.a = 2'b10; e.o.b = 2'b01; e.o.imm = (o == OP_SW) ? 2'b01 : 2'b00;
            step(1'($urandom), 7'($urandom), e, 1'b0);
            for (int i = 0; i <= mw; i++) begin
                e = blank((o == OP_SW) ? 4'd5 : 4'd3);
                e.o.adr = 1'b1; e.o.mw = (o == OP_SW);
                step((i == mw) && !abort, 7'($urandom), e, 1'b0);
                if (abort) begin
                    @(posedge clk);
                    #1;
                    mem_ready = 1'b0;
                    rst_n     = 1'b0;
                    #1;
                    chk("abort_state", 32'(state_o), 32'd0);
                    chk("abort_memwrite", 32'(MemWrite), 32'd0);
                    chk("abort_instret", instret, 32'd0);
                    cnt = 32'd0;
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    return;
                end
            end
            if (o == OP_LW) begin
                e = blank(4'd4);
                e.o.rs = 2'b01; e.o.rw = 1'b1;
                step(1'($urandom), 7'($urandom), e, 1'b0);
            end
        end else if (o == OP_BEQ) begin
            e = blank(4'd9);
            e.o.a = 2'b10; e.o.aop = 2'b01; e.o.br = 1'b1;
            step(1'($urandom), 7'($urandom), e, 1'b0);
        end else begin
            e = blank((o == OP_R) ? 4'd6 : 4'd7);
            e.o.a = 2'b10; e.o.aop = 2'b10;
            e.o.b = (o == OP_R) ? 2'b00 : 2'b01;
            step(1'($urandom), 7'($urandom), e, 1'b0);
            e = blank(4'd8);
            e.o.rw = 1'b1;
            step(1'($urandom), 7'($urandom), e, 1'b0);
        end
        cnt = cnt + 32'd1;
    endtask

    initial begin
        logic [6:0] rop;
        logic [6:0] legal_ops [5];
        legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ};
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        op        = 7'd0;
        cnt       = 32'd0;
        #3;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_illegal", 32'(illegal_op), 32'd0);
        chk("reset_memwrite", 32'(MemWrite), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(OP_R,        0, 0, 1'b0, 1'b0);
        chk("instret_after_r", 32'(cnt), 32'd1);
        run_instr(OP_LW,       3, 2, 1'b0, 1'b0);
        run_instr(OP_SW,       0, 2, 1'b0, 1'b0);
        run_instr(7'b1111111,  0, 0, 1'b0, 1'b0);
        run_instr(OP_BEQ,      1, 0, 1'b1, 1'b0);
        run_instr(OP_I,        0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                rop = 7'($urandom);
                if (rop inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ}) rop = 7'b1111111;
            end else begin
                rop = legal_ops[$urandom_range(0, 4)];
            end
            run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
        end

        run_instr(OP_SW, 1, 2, 1'b0, 1'b1);
        run_instr(OP_R,  0, 0, 1'b0, 1'b0);
        run_instr(OP_LW, 0, 0, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
